// File: rtl/pipe_ma_if.sv
// pipe_ma_if: bundles every non-clock/non-reset signal of the memory-access
// stage so the stage and its surroundings connect through one port.
//
// Signal groups:
//   EX -> MA record  : in_valid/in_ready, ans_in, dout_in, rw_e_in, rw_len_in,
//                      ld_uns_in, wb_e_in, wb_idx_in
//   Memory port      : mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
//                      mem_ack, mem_rdata
//   MA -> WB record  : out_valid/out_ready, wb_e_out, wb_idx_out, wb_val_out
//   Forwarding       : fwd_valid, fwd_idx, fwd_val
//   Status           : err
//
// Modports:
//   master : the memory-access stage (issues memory requests, owns outputs)
//   slave  : the environment (EX stage, memory, WB stage)
interface pipe_ma_if #(
    parameter int REG_SZ = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_SZ-1:0] ans_in;
    logic [REG_SZ-1:0] dout_in;
    logic [1:0]        rw_e_in;
    logic [1:0]        rw_len_in;
    logic              ld_uns_in;
    logic              wb_e_in;
    logic [4:0]        wb_idx_in;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    logic              out_valid;
    logic              out_ready;
    logic              wb_e_out;
    logic [4:0]        wb_idx_out;
    logic [REG_SZ-1:0] wb_val_out;

    logic              fwd_valid;
    logic [4:0]        fwd_idx;
    logic [REG_SZ-1:0] fwd_val;

    logic              err;

    modport master (
        input  in_valid, ans_in, dout_in, rw_e_in, rw_len_in, ld_uns_in,
               wb_e_in, wb_idx_in,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata,
        output out_valid, wb_e_out, wb_idx_out, wb_val_out,
        input  out_ready,
        output fwd_valid, fwd_idx, fwd_val,
        output err
    );

    modport slave (
        output in_valid, ans_in, dout_in, rw_e_in, rw_len_in, ld_uns_in,
               wb_e_in, wb_idx_in,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata,
        input  out_valid, wb_e_out, wb_idx_out, wb_val_out,
        output out_ready,
        input  fwd_valid, fwd_idx, fwd_val,
        input  err
    );
endinterface

// File: rtl/pipe_ma.sv
// pipe_ma: memory-access pipeline stage sitting directly after execute.
//
// Takes one EX record at a time (ALU result or effective address, store data,
// access type/length, writeback target), performs an optional byte/half/word
// load or store over a single-outstanding req/ack memory port, and presents
// the finished writeback record to WB through a valid/ready buffer. While a
// register-writing record is held, it is also driven onto the MA->EX
// forwarding bus.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - pipe_ma_if.master: EX record in, memory port, WB record out,
//          forwarding pair and the sticky err flag (misalignment / timeout)
//
// Parameters:
//   REG_SZ      - datapath width (>= 32)
//   ADDR_W      - memory address width, taken from the low bits of ans
//   TIMEOUT_CYC - cycles to wait for mem_ack before aborting (1..65535)
module pipe_ma #(
    parameter int REG_SZ      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input logic       clk,
    input logic       rst,
    pipe_ma_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Little-endian byte-lane enables for a store.
    function automatic logic [3:0] lane_mask(input logic [1:0] len,
                                             input logic [1:0] off);
        case (len)
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the mask alone selects the bytes.
    function automatic logic [31:0] lane_wdata(input logic [1:0]  len,
                                               input logic [31:0] d);
        case (len)
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    // Pick the addressed lane out of the read word and extend it.
    function automatic logic [REG_SZ-1:0] load_ext(input logic [31:0] word,
                                                   input logic [1:0]  off,
                                                   input logic [1:0]  len,
                                                   input logic        uns);
        logic [31:0]              sh;
        logic signed [REG_SZ-1:0] ext;
        sh = word >> {off, 3'b000};
        case (len)
            2'b00: begin
                if (uns) ext = REG_SZ'(sh[7:0]);
                else     ext = REG_SZ'($signed(sh[7:0]));
            end
            2'b01: begin
                if (uns) ext = REG_SZ'(sh[15:0]);
                else     ext = REG_SZ'($signed(sh[15:0]));
            end
            default: begin
                if (uns) ext = REG_SZ'(sh);
                else     ext = REG_SZ'($signed(sh));
            end
        endcase
        load_ext = ext;
    endfunction

    state_t            state;
    logic [15:0]       tmo_cnt;

    // Memory-request registers (drive the memory port directly).
    logic              req_p1;
    logic              we_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [31:0]       wdata_p1;
    logic [3:0]        wmask_p1;

    // Record fields latched at accept, used when the memory access completes.
    logic [REG_SZ-1:0] ans_p1;
    logic [1:0]        len_p1;
    logic              uns_p1;
    logic              store_p1;
    logic              wb_e_p1;
    logic [4:0]        wb_idx_p1;

    // Writeback buffer and forwarding registers.
    logic              vld_p2;
    logic              wb_e_p2;
    logic [4:0]        wb_idx_p2;
    logic [REG_SZ-1:0] wb_val_p2;
    logic              fwd_vld_p2;
    logic [4:0]        fwd_idx_p2;
    logic [REG_SZ-1:0] fwd_val_p2;
    logic              err_r;

    logic              in_ready_c;
    logic              acc;
    logic              in_none;
    logic              in_st;
    logic              in_misal;
    logic              in_fwd;
    logic [REG_SZ-1:0] ld_val;
    logic [REG_SZ-1:0] mem_val;
    logic              mem_wb_e;
    logic              mem_fwd;

    // A held record can drain and be replaced by a new one in the same cycle.
    assign in_ready_c = ((state == IDLE) && !vld_p2) ||
                        ((state == HOLD) && bus.out_ready);
    assign acc        = bus.in_valid && in_ready_c;

    always_comb begin
        in_none  = (bus.rw_e_in == 2'b00) || (bus.rw_e_in == 2'b11);
        in_st    = (bus.rw_e_in == 2'b10);
        in_misal = 1'b0;
        if (!in_none) begin
            case (bus.rw_len_in)
                2'b00:   in_misal = 1'b0;
                2'b01:   in_misal = bus.ans_in[0];
                default: in_misal = (bus.ans_in[1:0] != 2'b00);
            endcase
        end
        in_fwd   = bus.wb_e_in && (bus.wb_idx_in != 5'd0);

        ld_val   = load_ext(bus.mem_rdata, ans_p1[1:0], len_p1, uns_p1);
        mem_val  = store_p1 ? ans_p1 : ld_val;
        mem_wb_e = wb_e_p1 && !store_p1;
        mem_fwd  = mem_wb_e && (wb_idx_p1 != 5'd0);
    end

    // ---- p1: record capture at accept ----
    always_ff @(posedge clk) begin
        if (acc) begin
            ans_p1    <= bus.ans_in;
            len_p1    <= bus.rw_len_in;
            uns_p1    <= bus.ld_uns_in;
            store_p1  <= in_st;
            wb_e_p1   <= bus.wb_e_in;
            wb_idx_p1 <= bus.wb_idx_in;
        end
    end

    // ---- p1 -> p2: control FSM, memory request and writeback buffer ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            req_p1     <= 1'b0;
            we_p1      <= 1'b0;
            addr_p1    <= '0;
            wdata_p1   <= '0;
            wmask_p1   <= '0;
            vld_p2     <= 1'b0;
            wb_e_p2    <= 1'b0;
            wb_idx_p2  <= '0;
            wb_val_p2  <= '0;
            fwd_vld_p2 <= 1'b0;
            fwd_idx_p2 <= '0;
            fwd_val_p2 <= '0;
            err_r      <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (acc) begin
                        tmo_cnt <= '0;
                        if (in_none) begin
                            state      <= HOLD;
                            vld_p2     <= 1'b1;
                            wb_e_p2    <= bus.wb_e_in;
                            wb_idx_p2  <= bus.wb_idx_in;
                            wb_val_p2  <= bus.ans_in;
                            fwd_vld_p2 <= in_fwd;
                            fwd_idx_p2 <= in_fwd ? bus.wb_idx_in : 5'd0;
                            fwd_val_p2 <= bus.ans_in;
                        end else if (in_misal) begin
                            // Aborted access still produces a (non-writing)
                            // record so the pipeline keeps its ordering.
                            state      <= HOLD;
                            err_r      <= 1'b1;
                            vld_p2     <= 1'b1;
                            wb_e_p2    <= 1'b0;
                            wb_idx_p2  <= bus.wb_idx_in;
                            wb_val_p2  <= bus.ans_in;
                            fwd_vld_p2 <= 1'b0;
                            fwd_idx_p2 <= 5'd0;
                        end else begin
                            state      <= MEM;
                            req_p1     <= 1'b1;
                            we_p1      <= in_st;
                            addr_p1    <= {bus.ans_in[ADDR_W-1:2], 2'b00};
                            wdata_p1   <= in_st ? lane_wdata(bus.rw_len_in, bus.dout_in[31:0])
                                                : 32'd0;
                            wmask_p1   <= in_st ? lane_mask(bus.rw_len_in, bus.ans_in[1:0])
                                                : 4'b1111;
                            vld_p2     <= 1'b0;
                            fwd_vld_p2 <= 1'b0;
                            fwd_idx_p2 <= 5'd0;
                        end
                    end else if ((state == HOLD) && bus.out_ready) begin
                        state      <= IDLE;
                        vld_p2     <= 1'b0;
                        fwd_vld_p2 <= 1'b0;
                        fwd_idx_p2 <= 5'd0;
                    end
                end

                MEM: begin
                    // An ack arriving on the last allowed cycle still wins.
                    if (bus.mem_ack) begin
                        state      <= HOLD;
                        req_p1     <= 1'b0;
                        vld_p2     <= 1'b1;
                        wb_e_p2    <= mem_wb_e;
                        wb_idx_p2  <= wb_idx_p1;
                        wb_val_p2  <= mem_val;
                        fwd_vld_p2 <= mem_fwd;
                        fwd_idx_p2 <= mem_fwd ? wb_idx_p1 : 5'd0;
                        fwd_val_p2 <= mem_val;
                    end else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        state      <= HOLD;
                        req_p1     <= 1'b0;
                        err_r      <= 1'b1;
                        vld_p2     <= 1'b1;
                        wb_e_p2    <= 1'b0;
                        wb_idx_p2  <= wb_idx_p1;
                        wb_val_p2  <= ans_p1;
                        fwd_vld_p2 <= 1'b0;
                        fwd_idx_p2 <= 5'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.mem_req    = req_p1;
    assign bus.mem_we     = we_p1;
    assign bus.mem_addr   = addr_p1;
    assign bus.mem_wdata  = wdata_p1;
    assign bus.mem_wmask  = wmask_p1;
    assign bus.out_valid  = vld_p2;
    assign bus.wb_e_out   = wb_e_p2;
    assign bus.wb_idx_out = wb_idx_p2;
    assign bus.wb_val_out = wb_val_p2;
    assign bus.fwd_valid  = fwd_vld_p2;
    assign bus.fwd_idx    = fwd_idx_p2;
    assign bus.fwd_val    = fwd_val_p2;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_pipe_ma.sv
// tb_pipe_ma: self-checking bench for pipe_ma. Directed scenarios followed by
// randomized records, all checked against a behavioural model (byte-addressed
// memory image plus arithmetic lane/extension rules).
module tb_pipe_ma;

    localparam int REG_SZ = 32;
    localparam int ADDR_W = 32;
    localparam int TMO    = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_ma_if #(.REG_SZ(REG_SZ), .ADDR_W(ADDR_W)) bus ();

    pipe_ma #(
        .REG_SZ     (REG_SZ),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] mem_img [64];
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules written as plain arithmetic on the byte offset.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                             input int len, input bit uns);
        int unsigned v;
        v = w >> (8 * off);
        if (len == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (len == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_mask(input int len, input int off);
        if (len == 0) return 32'(1 << off);
        if (len == 1) return 32'(3 << off);
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input int len, input logic [31:0] d);
        if (len == 0) return (d % 256) * 32'h01010101;
        if (len == 1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    task automatic drive_rec(input logic [1:0] rw, input logic [1:0] len,
                             input logic [31:0] ans, input logic [31:0] dout,
                             input logic uns, input logic wbe, input logic [4:0] idx);
        bus.in_valid  = 1'b1;
        bus.rw_e_in   = rw;
        bus.rw_len_in = len;
        bus.ans_in    = ans;
        bus.dout_in   = dout;
        bus.ld_uns_in = uns;
        bus.wb_e_in   = wbe;
        bus.wb_idx_in = idx;
    endtask

    // One complete record: accept, optional memory access, writeback, drain.
    task automatic do_txn(input logic [1:0] rw, input logic [1:0] len,
                          input logic [31:0] ans, input logic [31:0] dout,
                          input logic uns, input logic wbe, input logic [4:0] idx,
                          input int ack_dly);
        int          off;
        int          ln;
        bit          none;
        bit          st;
        bit          misal;
        int          waited;
        bit          exp_we;
        bit          exp_fv;
        logic [31:0] exp_val;
        logic [31:0] word;
        logic [31:0] wd;
        logic [31:0] mk;
        off   = int'(ans[1:0]);
        ln    = int'(len);
        none  = (rw == 2'b00) || (rw == 2'b11);
        st    = (rw == 2'b10);
        misal = !none && ((ln == 1 && off % 2 == 1) || (ln >= 2 && off != 0));

        bus.out_ready = 1'b1;
        drive_rec(rw, len, ans, dout, uns, wbe, idx);
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            step();
            waited++;
        end
        check("in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;

        exp_val = ans;
        exp_we  = 1'b0;
        if (none) begin
            exp_we = wbe;
            check("no_req_alu", 32'(bus.mem_req), 32'd0);
        end else if (misal) begin
            exp_err = 1'b1;
            check("no_req_misal", 32'(bus.mem_req), 32'd0);
        end else begin
            check("req", 32'(bus.mem_req), 32'd1);
            check("addr", bus.mem_addr, ans & 32'hFFFFFFFC);
            check("we", 32'(bus.mem_we), 32'(st));
            mk = st ? ref_mask(ln, off) : 32'd15;
            check("wmask", 32'(bus.mem_wmask), mk);
            wd = ref_wdata(ln, dout);
            if (st) check("wdata", bus.mem_wdata, wd);
            for (int i = 0; i < ack_dly; i++) begin
                step();
                check("req_hold", 32'(bus.mem_req), 32'd1);
            end
            word = mem_img[ans[7:2]];
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = st ? $urandom : word;
            step();
            bus.mem_ack   = 1'b0;
            check("req_drop", 32'(bus.mem_req), 32'd0);
            if (st) begin
                for (int b = 0; b < 4; b++)
                    if (mk[b]) mem_img[ans[7:2]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_val = ref_load(word, off, ln, uns);
                exp_we  = wbe;
            end
        end

        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("wb_e_out", 32'(bus.wb_e_out), 32'(exp_we));
        if (exp_we) begin
            check("wb_idx", 32'(bus.wb_idx_out), 32'(idx));
            check("wb_val", bus.wb_val_out, exp_val);
        end
        exp_fv = exp_we && (idx != 5'd0);
        check("fwd_valid", 32'(bus.fwd_valid), 32'(exp_fv));
        check("fwd_idx", 32'(bus.fwd_idx), exp_fv ? 32'(idx) : 32'd0);
        if (exp_fv) check("fwd_val", bus.fwd_val, exp_val);
        check("err", 32'(bus.err), 32'(exp_err));

        step();
        check("drained", 32'(bus.out_valid), 32'd0);
        check("fwd_cleared", 32'(bus.fwd_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 64; i++) mem_img[i] = $urandom;
        rst           = 1'b1;
        exp_err       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ans_in    = '0;
        bus.dout_in   = '0;
        bus.rw_e_in   = 2'b00;
        bus.rw_len_in = 2'b00;
        bus.ld_uns_in = 1'b0;
        bus.wb_e_in   = 1'b0;
        bus.wb_idx_in = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.out_ready = 1'b0;

        step(); step(); step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        check("rst_fwd_idx", 32'(bus.fwd_idx), 32'd0);
        check("rst_wb_val", bus.wb_val_out, 32'd0);
        rst = 1'b0;
        step();
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // ALU pass-through.
        do_txn(2'b00, 2'b10, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5, 0);

        // Signed / unsigned byte loads from the top lane.
        mem_img[0] = 32'h80AABBCC;
        do_txn(2'b01, 2'b00, 32'h103, 32'h0, 1'b0, 1'b1, 5'd6, 2);
        do_txn(2'b01, 2'b00, 32'h103, 32'h0, 1'b1, 1'b1, 5'd6, 2);

        // Half store to the upper half, then read it back as a signed half.
        do_txn(2'b10, 2'b01, 32'h202, 32'h0000BEEF, 1'b0, 1'b1, 5'd8, 1);
        do_txn(2'b01, 2'b01, 32'h202, 32'h0, 1'b0, 1'b1, 5'd9, 0);

        // Misaligned word load.
        do_txn(2'b01, 2'b10, 32'h201, 32'h0, 1'b0, 1'b1, 5'd4, 0);

        // Timeout with late ack ignored.
        bus.out_ready = 1'b0;
        drive_rec(2'b01, 2'b10, 32'h40, 32'h0, 1'b0, 1'b1, 5'd3);
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.mem_req && n < 20) begin
            n++;
            step();
        end
        exp_err = 1'b1;
        check("tmo_req_cycles", 32'(n), 32'd4);
        check("tmo_err", 32'(bus.err), 32'd1);
        check("tmo_out_valid", 32'(bus.out_valid), 32'd1);
        check("tmo_wb_e", 32'(bus.wb_e_out), 32'd0);
        check("tmo_fwd", 32'(bus.fwd_valid), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h12345678;
        step();
        bus.mem_ack   = 1'b0;
        check("late_ack_valid", 32'(bus.out_valid), 32'd1);
        check("late_ack_req", 32'(bus.mem_req), 32'd0);
        check("late_ack_wb_e", 32'(bus.wb_e_out), 32'd0);
        bus.out_ready = 1'b1;
        step();
        check("tmo_drain", 32'(bus.out_valid), 32'd0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("idle_ack_valid", 32'(bus.out_valid), 32'd0);
        check("idle_ack_req", 32'(bus.mem_req), 32'd0);

        // Backpressure, then drain and accept in the same cycle.
        bus.out_ready = 1'b0;
        drive_rec(2'b00, 2'b00, 32'hCAFE0001, 32'h0, 1'b0, 1'b1, 5'd7);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_val", bus.wb_val_out, 32'hCAFE0001);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        drive_rec(2'b00, 2'b00, 32'h55AA, 32'h0, 1'b0, 1'b1, 5'd9);
        bus.out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_val", bus.wb_val_out, 32'h55AA);
        check("b2b_fwd_idx", 32'(bus.fwd_idx), 32'd9);
        step();
        check("b2b_drain", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a memory request.
        drive_rec(2'b01, 2'b10, 32'h10, 32'h0, 1'b0, 1'b1, 5'd2);
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_req", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        #1;
        exp_err = 1'b0;
        check("rst_mid_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_err", 32'(bus.err), 32'd0);
        step();
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("post_rst_ack_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_ack_req", 32'(bus.mem_req), 32'd0);

        // Randomized records.
        for (int t = 0; t < 80; t++) begin
            do_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   $urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
